// File: rtl/sobel_frame_tx.sv
// Transmit side of the Sobel byte stream: a 4-byte header (width LE, height LE)
// followed by exactly width*height pixel bytes forwarded from an upstream source.
module sobel_frame_tx #(
  parameter int DATA_BITS = 8,
  parameter int DIM_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_BITS-1:0]  width_in,
  input  logic [DIM_BITS-1:0]  height_in,
  input  logic [DATA_BITS-1:0] pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  // Handshake: a byte moves on either side only when valid && ready are both
  // high at a rising clk edge; a held valid keeps its data stable until taken.

  localparam int HDR_BITS  = 2 * DIM_BITS;
  localparam int HDR_BYTES = HDR_BITS / DATA_BITS;
  localparam int IDX_BITS  = $clog2(HDR_BYTES + 1);
  localparam int CNT_BITS  = 2 * DIM_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PIX   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state;
  logic [HDR_BITS-1:0]   hdr_sr;
  logic [IDX_BITS-1:0]   hdr_idx;
  logic [CNT_BITS-1:0]   total;
  logic [CNT_BITS-1:0]   pix_cnt;
  logic                  load_ok;

  assign load_ok   = !valid_out || ready_out;
  assign pix_ready = (state == PIX) && load_ok;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdr_sr    <= '0;
      hdr_idx   <= '0;
      total     <= '0;
      pix_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (width_in != '0 && height_in != '0) begin
              // The first header byte goes out directly; the rest shift out of hdr_sr.
              data_out  <= width_in[DATA_BITS-1:0];
              valid_out <= 1'b1;
              hdr_sr    <= {height_in, width_in} >> DATA_BITS;
              hdr_idx   <= IDX_BITS'(1);
              total     <= CNT_BITS'(width_in) * CNT_BITS'(height_in);
              pix_cnt   <= '0;
              busy      <= 1'b1;
              state     <= HDR;
            end else begin
              done <= 1'b1;
            end
          end
        end
        HDR: begin
          if (load_ok) begin
            data_out  <= hdr_sr[DATA_BITS-1:0];
            valid_out <= 1'b1;
            hdr_sr    <= hdr_sr >> DATA_BITS;
            hdr_idx   <= hdr_idx + IDX_BITS'(1);
            if (hdr_idx == IDX_BITS'(HDR_BYTES - 1)) state <= PIX;
          end
        end
        PIX: begin
          if (load_ok) begin
            if (pix_valid) begin
              data_out  <= pix_data;
              valid_out <= 1'b1;
              pix_cnt   <= pix_cnt + CNT_BITS'(1);
              if (pix_cnt + CNT_BITS'(1) == total) state <= DRAIN;
            end else begin
              valid_out <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (valid_out && ready_out) begin
            valid_out <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_tx.sv
// Directed bench for sobel_frame_tx: header/pixel ordering, backpressure,
// zero-size frames, ignored restarts, async reset abort and back-to-back frames.
module tb_sobel_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_out;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int done_cnt, done_cyc, first_acc, last_acc;
  int stable_err, ready_err, bubble_cnt;
  int busy_at_done, busy_c1, timed_out;

  sobel_frame_tx #(.DATA_BITS(8), .DIM_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .width_in  (width_in),
    .height_in (height_in),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Expected stream: width LE16, height LE16, then base, base+1, ... (mod 256).
  function automatic void build_exp(input logic [15:0] w, input logic [15:0] h,
                                    input logic [7:0] base);
    int n;
    exp_q.delete();
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(h[7:0]);
    exp_q.push_back(h[15:8]);
    n = int'(w) * int'(h);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
  endfunction

  // Pulses start with w/h, then runs until done or the cycle budget expires.
  // Cycle 1 is the first cycle after the start edge.
  task automatic drive_frame(input logic [15:0] w, input logic [15:0] h,
                             input int rmode, input int gap_at, input int gap_len,
                             input int poke_at, input logic [7:0] base,
                             input int budget);
    int         c;
    int         pix_idx;
    logic       prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; first_acc = -1; last_acc = -1;
    stable_err = 0; ready_err = 0; bubble_cnt = 0;
    busy_at_done = -1; busy_c1 = -1; timed_out = 0;
    pix_idx = 0; prev_stall = 1'b0; prev_data = 8'h00;
    @(posedge clk); #1;
    width_in = w; height_in = h; start = 1'b1; pix_valid = 1'b0; ready_out = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    forever begin
      if (c == 1) busy_c1 = int'(busy);
      if (prev_stall && (data_out !== prev_data || valid_out !== 1'b1)) stable_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        busy_at_done = int'(busy);
        break;
      end
      if (c > budget) begin
        timed_out = 1;
        break;
      end
      ready_out = (rmode == 1) ? c[0] : 1'b1;
      pix_valid = (c < gap_at) || (c >= gap_at + gap_len);
      pix_data  = base + 8'(pix_idx);
      if (c == poke_at) begin
        start = 1'b1;
        width_in = 16'd9;
      end else begin
        start = 1'b0;
      end
      #1;
      if (busy === 1'b1 && valid_out !== 1'b1) bubble_cnt++;
      if (pix_ready === 1'b1 && valid_out === 1'b1 && ready_out === 1'b0) ready_err++;
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
        got_q.push_back(data_out);
        if (first_acc < 0) first_acc = c;
        last_acc = c;
      end
      if (pix_valid && pix_ready === 1'b1) pix_idx++;
      prev_stall = (valid_out === 1'b1 && ready_out === 1'b0);
      prev_data  = data_out;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    ready_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; width_in = '0; height_in = '0;
    pix_data = '0; pix_valid = 1'b0; ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({data_out, valid_out, pix_ready, busy, done, state_dbg} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs: data=%h valid=%b pix_ready=%b busy=%b done=%b state=%0d, expected all 0",
               data_out, valid_out, pix_ready, busy, done, state_dbg);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: valid=%b busy=%b done=%b, expected 0 0 0", valid_out, busy, done);
    end
  endtask

  task automatic test_basic();
    int mm;
    drive_frame(16'd3, 16'd2, 0, 0, 0, -1, 8'h10, 100);
    build_exp(16'd3, 16'd2, 8'h10);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0) begin
      n_err++;
      $display("FAIL basic_stream: got %0d bytes first diff idx %0d (got %h exp %h), expected %0d bytes",
               got_q.size(), mm, (mm >= 0) ? got_q[mm] : 8'h00, (mm >= 0) ? exp_q[mm] : 8'h00, exp_q.size());
    end
    n_vec++;
    if (first_acc != 1 || last_acc != 10) begin
      n_err++;
      $display("FAIL basic_timing: bytes on cycles %0d..%0d, expected 1..10", first_acc, last_acc);
    end
    n_vec++;
    if (done_cyc != 11 || timed_out != 0) begin
      n_err++;
      $display("FAIL basic_done: done on cycle %0d (timeout=%0d), expected 11", done_cyc, timed_out);
    end
    n_vec++;
    if (busy_c1 != 1 || busy_at_done != 0) begin
      n_err++;
      $display("FAIL basic_busy: busy at c1=%0d at done=%0d, expected 1 and 0", busy_c1, busy_at_done);
    end
  endtask

  task automatic test_backpressure();
    int mm;
    drive_frame(16'h0102, 16'h0001, 1, 0, 0, -1, 8'h00, 1500);
    build_exp(16'h0102, 16'h0001, 8'h00);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0) begin
      n_err++;
      $display("FAIL bp_stream: got %0d bytes first diff idx %0d (got %h exp %h), expected %0d bytes",
               got_q.size(), mm, (mm >= 0) ? got_q[mm] : 8'h00, (mm >= 0) ? exp_q[mm] : 8'h00, exp_q.size());
    end
    n_vec++;
    if (stable_err != 0) begin
      n_err++;
      $display("FAIL bp_stable: %0d stalled cycles changed data_out/valid_out, expected 0", stable_err);
    end
    n_vec++;
    if (ready_err != 0) begin
      n_err++;
      $display("FAIL bp_pix_ready: pix_ready high during stall %0d times, expected 0", ready_err);
    end
    n_vec++;
    if (done_cnt != 1 || timed_out != 0) begin
      n_err++;
      $display("FAIL bp_done: done count %0d timeout=%0d, expected 1 and 0", done_cnt, timed_out);
    end
  endtask

  task automatic test_zero_dim();
    drive_frame(16'd0, 16'd5, 0, 0, 0, -1, 8'h00, 20);
    n_vec++;
    if (done_cyc != 1 || got_q.size() != 0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL zero_dim_done: done cycle %0d bytes %0d valid=%b, expected 1, 0, 0",
               done_cyc, got_q.size(), valid_out);
    end
    n_vec++;
    if (busy_c1 != 0 || busy_at_done != 0) begin
      n_err++;
      $display("FAIL zero_dim_busy: busy c1=%0d at done=%0d, expected 0 0", busy_c1, busy_at_done);
    end
  endtask

  task automatic test_ignored_start_bubbles();
    int mm;
    drive_frame(16'd4, 16'd4, 0, 7, 3, 12, 8'h20, 200);
    build_exp(16'd4, 16'd4, 8'h20);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0) begin
      n_err++;
      $display("FAIL ignore_stream: got %0d bytes first diff idx %0d (got %h exp %h), expected %0d bytes",
               got_q.size(), mm, (mm >= 0) ? got_q[mm] : 8'h00, (mm >= 0) ? exp_q[mm] : 8'h00, exp_q.size());
    end
    n_vec++;
    if (bubble_cnt != 3) begin
      n_err++;
      $display("FAIL ignore_bubbles: %0d bubble cycles, expected 3", bubble_cnt);
    end
    n_vec++;
    if (done_cnt != 1 || timed_out != 0) begin
      n_err++;
      $display("FAIL ignore_done: done count %0d timeout=%0d, expected 1 and 0", done_cnt, timed_out);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_restart: busy=%b valid=%b after frame, expected 0 0", busy, valid_out);
    end
  endtask

  task automatic test_async_reset();
    int late_done;
    int mm;
    @(posedge clk); #1;
    width_in = 16'd3; height_in = 16'd3; start = 1'b1; ready_out = 1'b1;
    pix_valid = 1'b1; pix_data = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({data_out, valid_out, pix_ready, busy, done, state_dbg} !== 14'h0) begin
      n_err++;
      $display("FAIL async_reset: data=%h valid=%b pix_ready=%b busy=%b done=%b state=%0d, expected all 0",
               data_out, valid_out, pix_ready, busy, done, state_dbg);
    end
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || valid_out === 1'b1) late_done++;
    end
    n_vec++;
    if (late_done != 0) begin
      n_err++;
      $display("FAIL async_abort: %0d cycles with done/valid after abort, expected 0", late_done);
    end
    drive_frame(16'd2, 16'd2, 0, 0, 0, -1, 8'h40, 100);
    build_exp(16'd2, 16'd2, 8'h40);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0 || done_cnt != 1) begin
      n_err++;
      $display("FAIL after_reset_stream: got %0d bytes diff idx %0d done %0d, expected %0d bytes diff -1 done 1",
               got_q.size(), mm, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int mm;
    int dones;
    drive_frame(16'd2, 16'd1, 0, 0, 0, -1, 8'h70, 100);
    dones = done_cnt;
    build_exp(16'd2, 16'd1, 8'h70);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0) begin
      n_err++;
      $display("FAIL b2b_first: got %0d bytes diff idx %0d, expected %0d bytes diff -1",
               got_q.size(), mm, exp_q.size());
    end
    drive_frame(16'd1, 16'd1, 0, 0, 0, -1, 8'h90, 100);
    dones += done_cnt;
    build_exp(16'd1, 16'd1, 8'h90);
    mm = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    n_vec++;
    if (got_q.size() != exp_q.size() || mm >= 0 || first_acc != 1) begin
      n_err++;
      $display("FAIL b2b_second: got %0d bytes diff idx %0d first cycle %0d, expected %0d bytes diff -1 cycle 1",
               got_q.size(), mm, first_acc, exp_q.size());
    end
    n_vec++;
    if (dones != 2) begin
      n_err++;
      $display("FAIL b2b_done: %0d done pulses, expected 2", dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_ignored_start_bubbles();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
